// File: rtl/vram8_blit_engine_pkg.sv
// vram8_blit_engine_pkg: VRAM8 geometry constants and blit FSM encoding
package vram8_blit_engine_pkg;
    localparam int VRAM8_ADDR_W = 14;
    localparam int VRAM8_LEN_W  = 15;
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FILL  = 3'd1,
        ST_PRIME = 3'd2,
        ST_COPY  = 3'd3,
        ST_DONE  = 3'd4
    } blit_state_e;
    function automatic logic is_busy(blit_state_e s);
        return s inside {ST_FILL, ST_PRIME, ST_COPY};
    endfunction
endpackage

// File: rtl/vram8_blit_engine_if.sv
// vram8_blit_engine_if: command/status bundle and VRAM8 read/write port bundle
interface vram8_cmd_if #(
    parameter int ADDR_W = vram8_blit_engine_pkg::VRAM8_ADDR_W,
    parameter int LEN_W  = vram8_blit_engine_pkg::VRAM8_LEN_W
);
    logic              cmd_start;
    logic              cmd_copy;
    logic              cmd_vbonly;
    logic [ADDR_W-1:0] cmd_src;
    logic [ADDR_W-1:0] cmd_dst;
    logic [LEN_W-1:0]  cmd_len;
    logic [7:0]        cmd_fill;
    logic              abort;
    logic              busy;
    logic              done;
    modport master (
        output cmd_start, cmd_copy, cmd_vbonly, cmd_src, cmd_dst, cmd_len, cmd_fill, abort,
        input  busy, done
    );
    modport slave (
        input  cmd_start, cmd_copy, cmd_vbonly, cmd_src, cmd_dst, cmd_len, cmd_fill, abort,
        output busy, done
    );
endinterface

interface vram8_bus_if #(
    parameter int ADDR_W = vram8_blit_engine_pkg::VRAM8_ADDR_W
);
    logic [ADDR_W-1:0] vram8_rd_addr;
    logic [7:0]        vram8_q;
    logic [ADDR_W-1:0] vram8_wr_addr;
    logic [7:0]        vram8_d;
    logic              vram8_we;
    modport master (
        output vram8_rd_addr, vram8_wr_addr, vram8_d, vram8_we,
        input  vram8_q
    );
    modport slave (
        input  vram8_rd_addr, vram8_wr_addr, vram8_d, vram8_we,
        output vram8_q
    );
endinterface

// File: rtl/vram8_blit_counter.sv
// vram8_blit_counter: VRAM8 address register with load, modulo increment and hold
module vram8_blit_counter
    import vram8_blit_engine_pkg::*;
#(
    parameter int W = VRAM8_ADDR_W
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         load_i,
    input  logic         inc_i,
    input  logic [W-1:0] val_i,
    output logic [W-1:0] addr_o
);
    logic [W-1:0] addr_q, addr_d;
    always_comb addr_d = load_i ? val_i : inc_i ? addr_q + W'(1) : addr_q;
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) addr_q <= '0;
        else addr_q <= addr_d;
    end
    assign addr_o = addr_q;
endmodule

// File: rtl/vram8_blit_engine.sv
// vram8_blit_engine: fills or copies VRAM8 byte ranges, optionally only while vblank is high
// we_q marks the write presented this cycle; it retires (dst advances, count drops) at the next edge.
module vram8_blit_engine
    import vram8_blit_engine_pkg::*;
#(
    parameter int ADDR_W      = VRAM8_ADDR_W,
    parameter int LEN_W       = VRAM8_LEN_W,
    parameter bit VBLANK_GATE = 1'b1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        vblank,
    vram8_cmd_if.slave  cmd,
    vram8_bus_if.master vram
);
    blit_state_e       state_q, state_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d, left;
    logic [7:0]        fill_q;
    logic              vbonly_q;
    logic              we_q, we_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              start, start_stall, stall, last, src_inc;
    logic [ADDR_W-1:0] src_addr, dst_addr;

    assign start       = state_q == ST_IDLE && cmd.cmd_start;
    assign start_stall = VBLANK_GATE && cmd.cmd_vbonly && !vblank;
    assign stall       = VBLANK_GATE && vbonly_q && !vblank;
    assign left        = cnt_q - LEN_W'(we_q);
    assign last        = left == '0;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            fill_q   <= '0;
            vbonly_q <= 1'b0;
            we_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            if (start) begin
                fill_q   <= cmd.cmd_fill;
                vbonly_q <= cmd.cmd_vbonly;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (cmd.cmd_start) state_d = cmd.cmd_len == '0 ? ST_DONE : cmd.cmd_copy ? ST_PRIME : ST_FILL;
            ST_FILL:  state_d = cmd.abort ? ST_IDLE : last ? ST_DONE : ST_FILL;
            ST_PRIME: state_d = cmd.abort ? ST_IDLE : stall ? ST_PRIME : ST_COPY;
            ST_COPY:  state_d = cmd.abort ? ST_IDLE : last ? ST_DONE : ST_COPY;
            default:  state_d = ST_IDLE;
        endcase
    end

    // a new copy write always consumes the byte at rd_addr, so the read pointer moves with it
    always_comb begin
        busy_d  = is_busy(state_d);
        done_d  = state_d == ST_DONE;
        we_d    = (state_d == ST_FILL || state_d == ST_COPY) && !(start ? start_stall : stall);
        cnt_d   = start ? cmd.cmd_len : (state_q == ST_FILL || state_q == ST_COPY) ? left : cnt_q;
        src_inc = state_d == ST_COPY && we_d;
    end

    vram8_blit_counter #(.W(ADDR_W)) u_src (
        .clk    (clk),
        .resetn (resetn),
        .load_i (start),
        .inc_i  (src_inc),
        .val_i  (cmd.cmd_src),
        .addr_o (src_addr)
    );

    vram8_blit_counter #(.W(ADDR_W)) u_dst (
        .clk    (clk),
        .resetn (resetn),
        .load_i (start),
        .inc_i  (we_q),
        .val_i  (cmd.cmd_dst),
        .addr_o (dst_addr)
    );

    assign vram.vram8_rd_addr = src_addr;
    assign vram.vram8_wr_addr = dst_addr;
    assign vram.vram8_we      = we_q;
    assign vram.vram8_d       = state_q == ST_COPY ? vram.vram8_q : fill_q;
    assign cmd.busy           = busy_q;
    assign cmd.done           = done_q;
endmodule

// File: tb/tb_vram8_blit_engine.sv
// tb_vram8_blit_engine: directed fill/copy/stall/abort/reset jobs checked against a queue model of VRAM8 writes
module tb_vram8_blit_engine;
    import vram8_blit_engine_pkg::*;
    localparam int AW = VRAM8_ADDR_W;
    localparam int LW = VRAM8_LEN_W;
    typedef struct packed { logic [AW-1:0] a; logic [7:0] v; } wr_t;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic vblank;
    vram8_cmd_if #(.ADDR_W(AW), .LEN_W(LW)) cmd ();
    vram8_bus_if #(.ADDR_W(AW)) vram ();

    vram8_blit_engine #(.ADDR_W(AW), .LEN_W(LW), .VBLANK_GATE(1'b1)) dut (
        .clk    (clk),
        .resetn (resetn),
        .vblank (vblank),
        .cmd    (cmd),
        .vram   (vram)
    );

    always #5 clk = ~clk;

    // VRAM8 model: synchronous read, plus a bench-only preload port
    logic [7:0]    mem [1<<AW];
    logic [7:0]    ref_mem [1<<AW];
    logic [7:0]    q_r;
    logic          pre_we = 1'b0;
    logic [AW-1:0] pre_a = '0;
    logic [7:0]    pre_v = '0;
    assign vram.vram8_q = q_r;
    always @(posedge clk) begin
        q_r <= mem[vram.vram8_rd_addr];
        if (vram.vram8_we) mem[vram.vram8_wr_addr] <= vram.vram8_d;
        if (pre_we) mem[pre_a] <= pre_v;
    end

    bit vb_toggle = 1'b0;
    int vb_ph = 0;
    always @(negedge clk) begin
        vb_ph  = vb_toggle ? (vb_ph + 1) % 6 : 0;
        vblank = vb_toggle ? vb_ph >= 3 : 1'b1;
    end

    logic vb_edge = 1'b0;
    always @(posedge clk) vb_edge <= vblank;

    int  tests = 0;
    int  fails = 0;
    int  wr_cnt = 0;
    bit  gate_vb = 1'b0;
    wr_t exp_q[$];
    wr_t mon_e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // every write must match the model, and a vbonly write must be launched by an edge that saw vblank high
    always @(negedge clk) if (resetn) begin
        if (vram.vram8_we) begin
            wr_cnt++;
            chk("write_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                chk("wr_addr", vram.vram8_wr_addr, mon_e.a);
                chk("wr_data", vram.vram8_d, mon_e.v);
            end
            if (gate_vb) chk("vblank_gate", vb_edge, 1);
            chk("we_implies_busy", cmd.busy, 1);
        end
        if (cmd.busy) chk("busy_done_excl", cmd.done, 0);
    end

    task automatic poke(input logic [AW-1:0] a, input logic [7:0] v);
        pre_a = a;
        pre_v = v;
        pre_we = 1'b1;
        ref_mem[a] = v;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    task automatic model_job(input bit copy, input logic [AW-1:0] src, dst, input int len, input logic [7:0] fill);
        logic [AW-1:0] a;
        logic [7:0] v;
        for (int k = 0; k < len; k++) begin
            a = dst + AW'(k);
            v = copy ? ref_mem[src + AW'(k)] : fill;
            ref_mem[a] = v;
            exp_q.push_back({a, v});
        end
    endtask

    task automatic start_job(input bit copy, vbo, input logic [AW-1:0] src, dst, input int len,
                             input logic [7:0] fill, input bit ab);
        cmd.cmd_copy = copy;
        cmd.cmd_vbonly = vbo;
        cmd.cmd_src = src;
        cmd.cmd_dst = dst;
        cmd.cmd_len = LW'(len);
        cmd.cmd_fill = fill;
        cmd.abort = ab;
        cmd.cmd_start = 1'b1;
        @(negedge clk);
        cmd.cmd_start = 1'b0;
        cmd.abort = 1'b0;
    endtask

    task automatic job(input bit copy, vbo, input logic [AW-1:0] src, dst, input int len, input logic [7:0] fill);
        model_job(copy, src, dst, len, fill);
        gate_vb = vbo;
        start_job(copy, vbo, src, dst, len, fill, 1'b0);
    endtask

    task automatic run(input int from, output int dc, output int fw);
        dc = -1;
        fw = -1;
        for (int i = from; i < from + 400; i++) begin
            if (fw < 0 && vram.vram8_we) fw = i;
            if (cmd.done) begin
                dc = i;
                break;
            end
            @(negedge clk);
        end
        if (dc < 0) chk("done_timeout", 0, 1);
    endtask

    task automatic chk_region(input string name, input logic [AW-1:0] base, input int len);
        int bad = 0;
        for (int k = 0; k < len; k++) if (mem[base + AW'(k)] !== ref_mem[base + AW'(k)]) bad++;
        chk(name, bad, 0);
    endtask

    initial begin
        int dc, fw, w0, dseen;
        cmd.cmd_start = 1'b0;
        cmd.cmd_copy = 1'b0;
        cmd.cmd_vbonly = 1'b0;
        cmd.cmd_src = '0;
        cmd.cmd_dst = '0;
        cmd.cmd_len = '0;
        cmd.cmd_fill = '0;
        cmd.abort = 1'b0;
        @(negedge clk);
        chk("rst_busy", cmd.busy, 0);
        chk("rst_done", cmd.done, 0);
        chk("rst_we", vram.vram8_we, 0);
        chk("rst_rd_addr", vram.vram8_rd_addr, 0);
        chk("rst_wr_addr", vram.vram8_wr_addr, 0);
        chk("rst_d", vram.vram8_d, 0);
        poke(14'h0000, 8'h11);
        poke(14'h0001, 8'h22);
        poke(14'h0002, 8'h33);
        poke(14'h0400, 8'hEE);
        for (int i = 0; i < 16; i++) poke(14'h1000 + AW'(i), 8'(i * 7 + 3));
        resetn = 1'b1;
        @(negedge clk);

        w0 = wr_cnt;
        job(1'b0, 1'b0, 14'h0000, 14'h0100, 4, 8'hA5);
        chk("t1_busy", cmd.busy, 1);
        run(1, dc, fw);
        chk("t1_first_we", fw, 1);
        chk("t1_done_cycle", dc, 5);
        chk("t1_writes", wr_cnt - w0, 4);
        @(negedge clk);
        chk("t1_idle_busy", cmd.busy, 0);
        chk("t1_done_pulse", cmd.done, 0);
        chk("t1_mem", {mem[14'h0100], mem[14'h0101], mem[14'h0102], mem[14'h0103]}, 32'hA5A5A5A5);
        chk("t1_pending", exp_q.size(), 0);

        job(1'b1, 1'b0, 14'h0000, 14'h0200, 3, 8'h00);
        run(1, dc, fw);
        chk("t2_first_we", fw, 2);
        chk("t2_done_cycle", dc, 5);
        @(negedge clk);
        chk("t2_mem", {mem[14'h0200], mem[14'h0201], mem[14'h0202]}, 24'h112233);
        chk("t2_pending", exp_q.size(), 0);

        job(1'b0, 1'b0, 14'h0000, 14'h3FFE, 4, 8'h5C);
        run(1, dc, fw);
        chk("t3_done_cycle", dc, 5);
        @(negedge clk);
        chk("t3_wrap_mem", {mem[14'h3FFE], mem[14'h3FFF], mem[14'h0000], mem[14'h0001]}, 32'h5C5C5C5C);
        chk("t3_untouched", mem[14'h0002], 8'h33);

        vb_toggle = 1'b1;
        w0 = wr_cnt;
        job(1'b1, 1'b1, 14'h1000, 14'h2000, 16, 8'h00);
        run(1, dc, fw);
        chk("t4_writes", wr_cnt - w0, 16);
        chk("t4_stalled", dc > 18, 1);
        @(negedge clk);
        chk_region("t4_copy", 14'h2000, 16);
        chk("t4_last_byte", mem[14'h200F], 8'h6C);
        chk("t4_pending", exp_q.size(), 0);
        gate_vb = 1'b0;
        vb_toggle = 1'b0;

        w0 = wr_cnt;
        job(1'b0, 1'b0, 14'h0000, 14'h0600, 0, 8'h99);
        run(1, dc, fw);
        chk("t5_zero_done", dc, 1);
        chk("t5_zero_no_we", fw, -1);
        @(negedge clk);
        w0 = wr_cnt;
        job(1'b0, 1'b0, 14'h0000, 14'h0300, 6, 8'h3C);
        cmd.cmd_copy = 1'b1;
        cmd.cmd_dst = 14'h0400;
        cmd.cmd_len = LW'(2);
        cmd.cmd_start = 1'b1;
        @(negedge clk);
        cmd.cmd_start = 1'b0;
        run(2, dc, fw);
        chk("t5_busy_start_done", dc, 7);
        chk("t5_busy_start_writes", wr_cnt - w0, 6);
        @(negedge clk);
        chk("t5_ignored_dst", mem[14'h0400], 8'hEE);
        chk_region("t5_fill", 14'h0300, 6);

        w0 = wr_cnt;
        job(1'b0, 1'b0, 14'h0000, 14'h0500, 10, 8'h77);
        @(negedge clk);
        @(negedge clk);
        cmd.abort = 1'b1;
        @(negedge clk);
        cmd.abort = 1'b0;
        chk("t6_abort_busy", cmd.busy, 0);
        chk("t6_abort_we", vram.vram8_we, 0);
        chk("t6_abort_writes", (wr_cnt - w0) <= 3, 1);
        dseen = 0;
        for (int i = 0; i < 12; i++) begin
            if (cmd.done) dseen++;
            @(negedge clk);
        end
        chk("t6_abort_no_done", dseen, 0);
        exp_q.delete();

        w0 = wr_cnt;
        model_job(1'b0, 14'h0000, 14'h0700, 2, 8'h42);
        start_job(1'b0, 1'b0, 14'h0000, 14'h0700, 2, 8'h42, 1'b1);
        run(1, dc, fw);
        chk("t6_start_beats_abort", dc, 3);
        chk("t6_start_abort_writes", wr_cnt - w0, 2);
        @(negedge clk);

        job(1'b1, 1'b0, 14'h1000, 14'h3000, 16, 8'h00);
        repeat (4) @(negedge clk);
        #1 resetn = 1'b0;
        #1;
        chk("t6_rst_we", vram.vram8_we, 0);
        chk("t6_rst_busy", cmd.busy, 0);
        chk("t6_rst_done", cmd.done, 0);
        chk("t6_rst_rd_addr", vram.vram8_rd_addr, 0);
        chk("t6_rst_wr_addr", vram.vram8_wr_addr, 0);
        chk("t6_rst_d", vram.vram8_d, 0);
        @(negedge clk);
        exp_q.delete();
        resetn = 1'b1;
        @(negedge clk);
        job(1'b0, 1'b0, 14'h0000, 14'h0800, 1, 8'h5A);
        run(1, dc, fw);
        chk("t6_recover_done", dc, 2);
        @(negedge clk);
        chk("t6_recover_mem", mem[14'h0800], 8'h5A);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule
